// File: rtl/dcache_port_arbiter.sv
// Shares the single blocking data-cache port between loads and committed
// stores drained from the SDQ through a one-entry store buffer.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   flush_i                       kills in-flight / requesting loads
//   ld_req_*                      load request (vld/rdy, addr, tag)
//   ld_resp_*                     registered load response (1-cycle pulse)
//   sdq_issue_en_o/sdq_issue_*    SDQ pull handshake (1-cycle issue latency)
//   sdq_full_i                    forces store drain
//   mem_req_*/mem_resp_*          cache port, one outstanding transaction
module dcache_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,

    input  logic              ld_req_vld_i,
    output logic              ld_req_rdy_o,
    input  logic [ADDR_W-1:0] ld_req_addr_i,
    input  logic [TAG_W-1:0]  ld_req_tag_i,

    output logic              ld_resp_vld_o,
    output logic [DATA_W-1:0] ld_resp_data_o,
    output logic [TAG_W-1:0]  ld_resp_tag_o,

    output logic              sdq_issue_en_o,
    input  logic              sdq_issue_vld_i,
    input  logic [ADDR_W-1:0] sdq_issue_addr_i,
    input  logic [DATA_W-1:0] sdq_issue_data_i,
    input  logic              sdq_full_i,

    output logic              mem_req_vld_o,
    input  logic              mem_req_rdy_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    input  logic              mem_resp_vld_i,
    input  logic [DATA_W-1:0] mem_resp_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state_q, state_d;

    logic              st_buf_vld_q;
    logic [ADDR_W-1:0] st_buf_addr_q;
    logic [DATA_W-1:0] st_buf_data_q;

    logic              en_q;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic              kill_q;

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [TAG_W-1:0]  req_tag_q;

    logic              resp_vld_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [TAG_W-1:0]  resp_tag_q;

    logic is_idle;
    logic store_wins;
    logic ld_grant;
    logic st_grant;
    logic resp_done;
    logic ld_resp_ok;

    assign is_idle = (state_q == IDLE);

    assign store_wins = st_buf_vld_q
                      & (~ld_req_vld_i
                         | sdq_full_i
                         | (starve_cnt_q == CNT_MAX));

    // Both combinational outputs are gated by reset so every output
    // reads 0 while rst_ni is low.
    assign ld_req_rdy_o = rst_ni & is_idle & ~flush_i & ~store_wins;

    // en_q covers the SDQ issue latency: after one enable the buffer
    // may fill next cycle, so never enable twice in a row.
    assign sdq_issue_en_o = rst_ni & ~st_buf_vld_q & ~en_q;

    assign ld_grant  = ld_req_vld_i & ld_req_rdy_o;
    assign st_grant  = is_idle & store_wins;
    assign resp_done = (state_q == WAIT) & mem_resp_vld_i;

    // A flush in the response cycle drops the load as well as kill_q.
    assign ld_resp_ok = resp_done & ~req_we_q & ~kill_q & ~flush_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ld_grant | st_grant) state_d = REQ;
            REQ:  if (mem_req_rdy_i)       state_d = WAIT;
            WAIT: if (mem_resp_vld_i)      state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= sdq_issue_en_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_buf_vld_q  <= 1'b0;
            st_buf_addr_q <= '0;
            st_buf_data_q <= '0;
        end else begin
            if (st_grant) begin
                st_buf_vld_q <= 1'b0;
            end
            if (sdq_issue_vld_i) begin
                st_buf_vld_q  <= 1'b1;
                st_buf_addr_q <= sdq_issue_addr_i;
                st_buf_data_q <= sdq_issue_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else if (st_grant) begin
            starve_cnt_q <= '0;
        end else if (ld_grant & st_buf_vld_q & (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_tag_q   <= '0;
        end else if (ld_grant) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= ld_req_addr_i;
            req_wdata_q <= '0;
            req_tag_q   <= ld_req_tag_i;
        end else if (st_grant) begin
            req_we_q    <= 1'b1;
            req_addr_q  <= st_buf_addr_q;
            req_wdata_q <= st_buf_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kill_q <= 1'b0;
        end else if (ld_grant) begin
            kill_q <= 1'b0;
        end else if (flush_i & ~is_idle & ~req_we_q) begin
            kill_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            resp_vld_q <= ld_resp_ok;
            if (ld_resp_ok) begin
                resp_data_q <= mem_resp_rdata_i;
                resp_tag_q  <= req_tag_q;
            end
        end
    end

    assign mem_req_vld_o   = (state_q == REQ);
    assign mem_req_we_o    = req_we_q;
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_wdata_o = req_wdata_q;

    assign ld_resp_vld_o  = resp_vld_q;
    assign ld_resp_data_o = resp_data_q;
    assign ld_resp_tag_o  = resp_tag_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_dcache_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int SL = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          ld_req_vld_i;
    logic          ld_req_rdy_o;
    logic [AW-1:0] ld_req_addr_i;
    logic [TW-1:0] ld_req_tag_i;
    logic          ld_resp_vld_o;
    logic [DW-1:0] ld_resp_data_o;
    logic [TW-1:0] ld_resp_tag_o;
    logic          sdq_issue_en_o;
    logic          sdq_issue_vld_i;
    logic [AW-1:0] sdq_issue_addr_i;
    logic [DW-1:0] sdq_issue_data_i;
    logic          sdq_full_i;
    logic          mem_req_vld_o;
    logic          mem_req_rdy_i;
    logic          mem_req_we_o;
    logic [AW-1:0] mem_req_addr_o;
    logic [DW-1:0] mem_req_wdata_o;
    logic          mem_resp_vld_i;
    logic [DW-1:0] mem_resp_rdata_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    dcache_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .ld_req_vld_i(ld_req_vld_i), .ld_req_rdy_o(ld_req_rdy_o),
        .ld_req_addr_i(ld_req_addr_i), .ld_req_tag_i(ld_req_tag_i),
        .ld_resp_vld_o(ld_resp_vld_o), .ld_resp_data_o(ld_resp_data_o),
        .ld_resp_tag_o(ld_resp_tag_o),
        .sdq_issue_en_o(sdq_issue_en_o), .sdq_issue_vld_i(sdq_issue_vld_i),
        .sdq_issue_addr_i(sdq_issue_addr_i), .sdq_issue_data_i(sdq_issue_data_i),
        .sdq_full_i(sdq_full_i),
        .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o),
        .mem_resp_vld_i(mem_resp_vld_i), .mem_resp_rdata_i(mem_resp_rdata_i)
    );

    task automatic idle_inputs();
        flush_i = 0; ld_req_vld_i = 0; ld_req_addr_i = '0; ld_req_tag_i = '0;
        sdq_issue_vld_i = 0; sdq_issue_addr_i = '0; sdq_issue_data_i = '0;
        sdq_full_i = 0; mem_req_rdy_i = 0; mem_resp_vld_i = 0;
        mem_resp_rdata_i = '0;
    endtask

    // Waits for an enable, then returns one store one cycle later.
    // Returns at the negedge of the first cycle the buffer is valid.
    task automatic issue_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk_i); #1;
            seen = sdq_issue_en_o;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL issue_en_timeout: got 0 expected 1");
        end
        @(negedge clk_i);
        sdq_issue_vld_i = 1; sdq_issue_addr_i = a; sdq_issue_data_i = d;
        @(negedge clk_i);
        sdq_issue_vld_i = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0; idle_inputs();
        repeat (2) @(negedge clk_i);
        ld_req_vld_i = 1;
        #1;
        checks++;
        if ({sdq_issue_en_o, ld_req_rdy_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_en_rdy: got %b expected 00", {sdq_issue_en_o, ld_req_rdy_o});
        end
        checks++;
        if ({mem_req_vld_o, mem_req_we_o, ld_resp_vld_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_vld: got %b expected 000", {mem_req_vld_o, mem_req_we_o, ld_resp_vld_o});
        end
        ld_req_vld_i = 0;
    endtask

    task automatic test_store_drain();
        @(negedge clk_i); rst_ni = 1; #1;
        checks++;
        if (sdq_issue_en_o !== 1'b1) begin
            errors++; $display("FAIL first_en: got %b expected 1", sdq_issue_en_o);
        end
        @(negedge clk_i);
        sdq_issue_vld_i = 1; sdq_issue_addr_i = 32'h100; sdq_issue_data_i = 32'hDEAD;
        #1;
        checks++;
        if (sdq_issue_en_o !== 1'b0) begin
            errors++; $display("FAIL en_twice: got %b expected 0", sdq_issue_en_o);
        end
        @(negedge clk_i); sdq_issue_vld_i = 0; #1;
        checks++;
        if ({mem_req_vld_o, sdq_issue_en_o} !== 2'b00) begin
            errors++; $display("FAIL buf_full_idle: got %b expected 00", {mem_req_vld_o, sdq_issue_en_o});
        end
        @(negedge clk_i); mem_req_rdy_i = 1; #1;
        checks++;
        if ({mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} !== {2'b11, 32'h100, 32'hDEAD}) begin
            errors++;
            $display("FAIL store_req: got %b%b %h %h expected 11 100 dead",
                     mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o);
        end
        @(negedge clk_i); mem_req_rdy_i = 0; mem_resp_vld_i = 1; #1;
        checks++;
        if (mem_req_vld_o !== 1'b0) begin
            errors++; $display("FAIL store_wait: got %b expected 0", mem_req_vld_o);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i); mem_resp_vld_i = 0; #1;
            checks++;
            if (ld_resp_vld_o !== 1'b0) begin
                errors++; $display("FAIL store_no_resp: got %b expected 0", ld_resp_vld_o);
            end
        end
    endtask

    task automatic test_single_load();
        @(negedge clk_i);
        ld_req_vld_i = 1; ld_req_addr_i = 32'h40; ld_req_tag_i = 5'd7; mem_req_rdy_i = 1;
        #1;
        checks++;
        if (ld_req_rdy_o !== 1'b1) begin
            errors++; $display("FAIL load_rdy: got %b expected 1", ld_req_rdy_o);
        end
        @(negedge clk_i); ld_req_vld_i = 0; #1;
        checks++;
        if ({mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} !== {2'b10, 32'h40, 32'h0}) begin
            errors++;
            $display("FAIL load_req_c1: got %b%b %h %h expected 10 40 0",
                     mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o);
        end
        @(negedge clk_i); mem_resp_vld_i = 1; mem_resp_rdata_i = 32'h1234; #1;
        checks++;
        if (ld_resp_vld_o !== 1'b0) begin
            errors++; $display("FAIL load_early: got %b expected 0", ld_resp_vld_o);
        end
        @(negedge clk_i); mem_resp_vld_i = 0; mem_resp_rdata_i = 32'h0; #1;
        checks++;
        if ({ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o} !== {1'b1, 32'h1234, 5'd7}) begin
            errors++;
            $display("FAIL load_resp_c3: got %b %h %0d expected 1 1234 7",
                     ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o);
        end
        @(negedge clk_i); #1;
        checks++;
        if ({ld_resp_vld_o, ld_resp_data_o} !== {1'b0, 32'h1234}) begin
            errors++;
            $display("FAIL load_hold: got %b %h expected 0 1234", ld_resp_vld_o, ld_resp_data_o);
        end
        mem_req_rdy_i = 0;
    endtask

    task automatic test_starvation();
        for (int rep = 0; rep < 2; rep++) begin
            bit en_seen = 0, issued = 0, buffered = 0, done = 0;
            bit resp_due = 0, prev_rdy = 1;
            int n_ld = 0;
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                @(negedge clk_i);
                sdq_issue_vld_i = en_seen && !issued;
                sdq_issue_addr_i = 32'h500 + rep;
                sdq_issue_data_i = 32'hA000 + rep;
                mem_resp_vld_i = resp_due;
                mem_resp_rdata_i = $urandom;
                ld_req_vld_i = 1; ld_req_addr_i = cyc; ld_req_tag_i = TW'(cyc);
                mem_req_rdy_i = 1;
                #1;
                if (mem_req_vld_o && mem_req_we_o) begin
                    done = 1;
                    checks++;
                    if (n_ld != SL || mem_req_addr_o !== 32'h500 + rep) begin
                        errors++;
                        $display("FAIL starve_count: got %0d loads addr %h expected %0d addr %h",
                                 n_ld, mem_req_addr_o, SL, 32'h500 + rep);
                    end
                    checks++;
                    if (prev_rdy !== 1'b0) begin
                        errors++; $display("FAIL starve_rdy: got %b expected 0", prev_rdy);
                    end
                end else begin
                    if (ld_req_vld_i && ld_req_rdy_o && buffered) n_ld++;
                    resp_due = mem_req_vld_o & mem_req_rdy_i;
                    prev_rdy = ld_req_rdy_o;
                    en_seen = sdq_issue_en_o;
                    if (sdq_issue_vld_i) begin
                        issued = 1; buffered = 1;
                    end
                end
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL starve_timeout: got no store expected store");
            end
            @(negedge clk_i);
            ld_req_vld_i = 0; mem_req_rdy_i = 0; mem_resp_vld_i = 1;
            @(negedge clk_i); mem_resp_vld_i = 0;
            @(negedge clk_i);
        end
    endtask

    task automatic test_sdq_full();
        issue_store(32'h200, 32'h55);
        ld_req_vld_i = 1; ld_req_addr_i = 32'h90; ld_req_tag_i = 5'd2; sdq_full_i = 1;
        #1;
        checks++;
        if (ld_req_rdy_o !== 1'b0) begin
            errors++; $display("FAIL full_rdy: got %b expected 0", ld_req_rdy_o);
        end
        @(negedge clk_i); mem_req_rdy_i = 1; #1;
        checks++;
        if ({mem_req_vld_o, mem_req_we_o, mem_req_addr_o} !== {2'b11, 32'h200}) begin
            errors++;
            $display("FAIL full_store: got %b%b %h expected 11 200",
                     mem_req_vld_o, mem_req_we_o, mem_req_addr_o);
        end
        @(negedge clk_i);
        ld_req_vld_i = 0; sdq_full_i = 0; mem_req_rdy_i = 0; mem_resp_vld_i = 1;
        @(negedge clk_i); mem_resp_vld_i = 0;
    endtask

    // Load with cache ready and a 1-cycle response; optional flush
    // coincident with the response.
    task automatic run_load(input logic [AW-1:0] a, input logic [TW-1:0] t,
                            input logic [DW-1:0] d, input bit fl, input string nm);
        @(negedge clk_i);
        ld_req_vld_i = 1; ld_req_addr_i = a; ld_req_tag_i = t; mem_req_rdy_i = 1;
        @(negedge clk_i); ld_req_vld_i = 0;
        @(negedge clk_i);
        mem_req_rdy_i = 0; mem_resp_vld_i = 1; mem_resp_rdata_i = d; flush_i = fl;
        @(negedge clk_i); mem_resp_vld_i = 0; flush_i = 0; #1;
        checks++;
        if (fl && ld_resp_vld_o !== 1'b0) begin
            errors++; $display("FAIL %s: got vld %b expected 0", nm, ld_resp_vld_o);
        end else if (!fl && {ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o} !== {1'b1, d, t}) begin
            errors++;
            $display("FAIL %s: got %b %h %0d expected 1 %h %0d",
                     nm, ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o, d, t);
        end
    endtask

    task automatic test_flush();
        @(negedge clk_i);
        ld_req_vld_i = 1; ld_req_addr_i = 32'h80; ld_req_tag_i = 5'd3; flush_i = 1;
        #1;
        checks++;
        if (ld_req_rdy_o !== 1'b0) begin
            errors++; $display("FAIL flush_idle_rdy: got %b expected 0", ld_req_rdy_o);
        end
        @(negedge clk_i); flush_i = 0; #1;
        checks++;
        if (ld_req_rdy_o !== 1'b1) begin
            errors++; $display("FAIL flush_retry_rdy: got %b expected 1", ld_req_rdy_o);
        end
        @(negedge clk_i); ld_req_vld_i = 0; mem_req_rdy_i = 1;
        @(negedge clk_i); mem_req_rdy_i = 0; flush_i = 1;
        @(negedge clk_i); flush_i = 0; mem_resp_vld_i = 1; mem_resp_rdata_i = 32'hBEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i); mem_resp_vld_i = 0; #1;
            checks++;
            if (ld_resp_vld_o !== 1'b0) begin
                errors++; $display("FAIL flush_drop: got %b expected 0", ld_resp_vld_o);
            end
        end
        run_load(32'h84, 5'd4, 32'h4444, 0, "flush_next_load");
        run_load(32'h88, 5'd9, 32'h9999, 1, "flush_same_cycle");
        run_load(32'h8C, 5'd11, 32'hBBBB, 0, "flush_after_load");
    endtask

    task automatic test_backpressure();
        issue_store(32'h300, 32'hCAFE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i); #1;
            checks++;
            if ({mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} !== {2'b11, 32'h300, 32'hCAFE}) begin
                errors++;
                $display("FAIL stall_stable: got %b%b %h %h expected 11 300 cafe",
                         mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o);
            end
        end
        @(negedge clk_i); mem_req_rdy_i = 1;
        @(negedge clk_i); mem_req_rdy_i = 0; #1;
        checks++;
        if (mem_req_vld_o !== 1'b0) begin
            errors++; $display("FAIL stall_wait: got %b expected 0", mem_req_vld_o);
        end
        ld_req_vld_i = 1;
        rst_ni = 0; #1;
        checks++;
        if ({mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} !== '0) begin
            errors++;
            $display("FAIL rst_mem: got %b%b %h %h expected 00 0 0",
                     mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o);
        end
        checks++;
        if ({ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o, sdq_issue_en_o, ld_req_rdy_o} !== '0) begin
            errors++;
            $display("FAIL rst_ld: got %b %h %0d %b %b expected all 0",
                     ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o, sdq_issue_en_o, ld_req_rdy_o);
        end
        ld_req_vld_i = 0;
    endtask

    task automatic test_random();
        localparam int N = 3000;
        logic [AW-1:0] la_q[$];
        logic [TW-1:0] lt_q[$];
        logic [AW-1:0] sa_q[$];
        logic [DW-1:0] sd_q[$];
        bit en_prev = 0, buffered = 0, ld_pend = 0, in_wait = 0;
        bit active = 0, cur_ld = 0, killed = 0;
        bit exp_vld = 0, prev_stall = 0, prev_req = 0;
        logic [DW-1:0] exp_data = '0;
        logic [TW-1:0] exp_tag = '0, cur_tag = '0;
        logic [AW-1:0] p_addr = '0;
        logic [DW-1:0] p_wdata = '0;
        logic p_we = 0;
        int delay = 0, n_starve = 0;
        idle_inputs();
        @(negedge clk_i); rst_ni = 1;
        for (int cyc = 0; cyc < N; cyc++) begin
            bit resp_now = 0;
            bit feed = cyc < N - 200;
            if (cyc > 0) @(negedge clk_i);
            sdq_issue_vld_i = en_prev && feed && ($urandom_range(0, 3) != 0);
            sdq_issue_addr_i = $urandom; sdq_issue_data_i = $urandom;
            sdq_full_i = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 15) == 0);
            if (!ld_pend && feed && $urandom_range(0, 2) == 0) begin
                ld_pend = 1; ld_req_addr_i = $urandom; ld_req_tag_i = TW'($urandom);
            end
            ld_req_vld_i = ld_pend;
            mem_req_rdy_i = ($urandom_range(0, 2) != 0);
            if (in_wait) begin
                if (delay == 0) resp_now = 1;
                else delay--;
            end
            mem_resp_vld_i = resp_now;
            mem_resp_rdata_i = $urandom;
            #1;
            checks++;
            if (ld_resp_vld_o !== exp_vld ||
                (exp_vld && {ld_resp_data_o, ld_resp_tag_o} !== {exp_data, exp_tag})) begin
                errors++;
                $display("FAIL rnd_resp cyc %0d: got %b %h %0d expected %b %h %0d", cyc,
                         ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o, exp_vld, exp_data, exp_tag);
            end
            if (prev_stall) begin
                checks++;
                if ({mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} !== {1'b1, p_we, p_addr, p_wdata}) begin
                    errors++;
                    $display("FAIL rnd_stable cyc %0d: got %b%b %h %h expected 1%b %h %h", cyc,
                             mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, p_we, p_addr, p_wdata);
                end
            end
            if (mem_req_vld_o && !prev_req) begin
                active = 1; killed = 0; cur_ld = !mem_req_we_o;
                checks++;
                if (mem_req_we_o) begin
                    if (sa_q.size() == 0) begin
                        errors++; $display("FAIL rnd_store cyc %0d: got %h expected none", cyc, mem_req_addr_o);
                    end else begin
                        if ({mem_req_addr_o, mem_req_wdata_o} !== {sa_q[0], sd_q[0]}) begin
                            errors++;
                            $display("FAIL rnd_store cyc %0d: got %h %h expected %h %h", cyc,
                                     mem_req_addr_o, mem_req_wdata_o, sa_q[0], sd_q[0]);
                        end
                        void'(sa_q.pop_front()); void'(sd_q.pop_front());
                    end
                    buffered = 0; n_starve = 0;
                end else begin
                    if (la_q.size() == 0) begin
                        errors++; $display("FAIL rnd_load cyc %0d: got %h expected none", cyc, mem_req_addr_o);
                    end else begin
                        if ({mem_req_addr_o, mem_req_wdata_o} !== {la_q[0], 32'h0}) begin
                            errors++;
                            $display("FAIL rnd_load cyc %0d: got %h %h expected %h 0", cyc,
                                     mem_req_addr_o, mem_req_wdata_o, la_q[0]);
                        end
                        void'(la_q.pop_front());
                        cur_tag = lt_q.pop_front();
                    end
                end
            end
            if (active && cur_ld && flush_i) killed = 1;
            checks++;
            if (sdq_issue_en_o && (buffered || en_prev)) begin
                errors++;
                $display("FAIL rnd_issue_en cyc %0d: got 1 expected 0 (buffered %b prev %b)",
                         cyc, buffered, en_prev);
            end
            if (ld_req_vld_i && ld_req_rdy_o) begin
                la_q.push_back(ld_req_addr_i); lt_q.push_back(ld_req_tag_i);
                ld_pend = 0;
                if (buffered) begin
                    n_starve++;
                    checks++;
                    if (n_starve > SL) begin
                        errors++;
                        $display("FAIL rnd_starve cyc %0d: got %0d loads expected <= %0d", cyc, n_starve, SL);
                    end
                end
            end
            if (mem_req_vld_o && mem_req_rdy_i) begin
                in_wait = 1; delay = $urandom_range(0, 3);
            end
            exp_vld = 0;
            if (resp_now) begin
                exp_vld = cur_ld && !killed;
                exp_data = mem_resp_rdata_i; exp_tag = cur_tag;
                active = 0; in_wait = 0;
            end
            prev_stall = mem_req_vld_o && !mem_req_rdy_i;
            prev_req = mem_req_vld_o;
            p_we = mem_req_we_o; p_addr = mem_req_addr_o; p_wdata = mem_req_wdata_o;
            en_prev = sdq_issue_en_o;
            if (sdq_issue_vld_i) begin
                buffered = 1;
                sa_q.push_back(sdq_issue_addr_i); sd_q.push_back(sdq_issue_data_i);
            end
        end
        checks++;
        if (sa_q.size() != 0 || la_q.size() != 0 || ld_pend || in_wait) begin
            errors++;
            $display("FAIL rnd_drain: got stores %0d loads %0d pend %b wait %b expected all 0",
                     sa_q.size(), la_q.size(), ld_pend, in_wait);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_drain();
        test_single_load();
        test_starvation();
        test_sdq_full();
        test_flush();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-cache port between the load unit and committed-store drain from the store data queue (SDQ).
- Pulls committed stores out of the SDQ through its issue handshake and holds them in a one-entry store buffer.
- Loads have priority; a starvation counter guarantees store forward progress, and full-SDQ drain mode does the same.
- Blocking port: one outstanding cache transaction; the arbiter sequences request, accept and response through a 3-state FSM.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TAG_W, 5, load tag width (ROB index)
- STARVE_LIMIT, 4, consecutive lost store arbitrations before the store is forced to win; must be ≥ 1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; kills in-flight and requesting loads
- ld_req_vld_i  in  1  load request valid
- ld_req_rdy_o  out  1  load accepted when vld&rdy
- ld_req_addr_i  in  ADDR_W  load address
- ld_req_tag_i  in  TAG_W  load tag
- ld_resp_vld_o  out  1  load data valid, 1-cycle pulse
- ld_resp_data_o  out  DATA_W  load data
- ld_resp_tag_o  out  TAG_W  tag of returning load
- sdq_issue_en_o  out  1  drives SDQ issue enable
- sdq_issue_vld_i  in  1  SDQ issued a store; registered SDQ output, one cycle after enable
- sdq_issue_addr_i  in  ADDR_W  issued store address
- sdq_issue_data_i  in  DATA_W  issued store data
- sdq_full_i  in  1  SDQ full; enables drain mode
- mem_req_vld_o  out  1  cache request valid
- mem_req_rdy_i  in  1  cache accepts request
- mem_req_we_o  out  1  1 = store, 0 = load
- mem_req_addr_o  out  ADDR_W  request address
- mem_req_wdata_o  out  DATA_W  store data; 0 for loads
- mem_resp_vld_i  in  1  cache response (read data or write ack)
- mem_resp_rdata_i  in  DATA_W  read data

Behaviour:
- Reset (async, rst_ni low): FSM = IDLE; store buffer empty; starve_cnt = 0; en_q = 0; kill = 0. All outputs 0, including sdq_issue_en_o, which is gated by reset.
- SDQ pull:
  - sdq_issue_en_o = ~st_buf_vld & ~en_q, where en_q is sdq_issue_en_o registered. This covers the SDQ's 1-cycle issue latency and prevents double issue.
  - sdq_issue_vld_i loads addr/data into the buffer and sets st_buf_vld.
  - sdq_issue_vld_i while st_buf_vld = 1 is a protocol violation. Verification asserts it never happens.
- FSM:
  - IDLE: arbitration each cycle.
    - store_wins = st_buf_vld & (~ld_req_vld_i | sdq_full_i | starve_cnt == STARVE_LIMIT).
    - ld_req_rdy_o = (state == IDLE) & ~flush_i & ~store_wins.
    - Load grant: latch addr/tag, we = 0, clear kill, go to REQ.
    - Store grant: move the buffer into request regs, clear st_buf_vld, starve_cnt <= 0, go to REQ.
    - Load granted while st_buf_vld = 1: starve_cnt increments, saturating at STARVE_LIMIT. Width is $clog2(STARVE_LIMIT+1).
    - A newly captured buffer entry is arbitrable the cycle after capture.
  - REQ: mem_req_vld_o = 1. Addr/we/wdata are held stable until mem_req_rdy_i; on accept go to WAIT. The request is never withdrawn, including on flush.
  - WAIT: on mem_resp_vld_i go to IDLE. The next arbitration happens in the following cycle.
- Load response:
  - ld_resp_vld_o is registered and pulses the cycle after mem_resp_vld_i for a non-killed load, with data and tag from that cycle.
  - Response data/tag are held until the next response; valid is 0 otherwise.
  - Store acks produce no ld_resp.
- Flush:
  - flush_i in REQ or WAIT with an in-flight load sets kill; that load's response is dropped.
  - flush_i in the same cycle as a load's mem_resp_vld_i also drops it.
  - flush_i in IDLE blocks load acceptance that cycle.
  - Stores, the store buffer and starve_cnt are unaffected by flush.
- Responses arriving outside WAIT are ignored (assertion).
- Minimum latency, load accepted at cycle 0 with cache always ready and response 1 cycle after accept:
  - REQ at cycle 1, mem_req_vld_o = 1 at cycle 1.
  - mem_resp_vld_i at cycle 2.
  - ld_resp_vld_o at cycle 3.

Test Plan:
- Reset release, idle cache: sdq_issue_en_o = 1 in the first cycle; SDQ returns store (addr 0x100, data 0xDEAD) → mem_req_vld_o = 1, we = 1, addr 0x100, wdata 0xDEAD; ack returns to IDLE; no ld_resp_vld_o.
- Single load addr 0x40, tag 7, rdy = 1, response data 0x1234 one cycle later → ld_resp_vld_o one pulse at cycle 3 with data 0x1234, tag 7.
- Buffered store plus continuous loads, STARVE_LIMIT = 4 → exactly 4 loads granted, then the store wins with ld_req_rdy_o = 0 that cycle; starve_cnt returns to 0.
- Buffered store, ld_req_vld_i = 1, sdq_full_i = 1 → store granted immediately.
- Load in WAIT, flush_i pulsed, then response 0xBEEF → no ld_resp_vld_o; the next load completes normally.
- mem_req_rdy_i held low for 5 cycles → mem_req_* stable throughout; sdq_issue_vld_i never fires while the buffer is full; asserting rst_ni low in WAIT clears all outputs immediately.
